// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and sequencer-state definitions for the 8-bit ALU and its controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_DEC = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd15;

    localparam int FLAG_C  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_OV = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_DEC);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port, async clear.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Requester-side controller for the gate-level ALU: fetches operands, holds them while the ALU
// settles, captures result and flags, writes back and returns the response over valid/ready.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 4,
    parameter int REG_AW   = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_ov,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags,
    output logic              out_err
);

    localparam int CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

    seq_state_e        state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        op_sel_q, op_sel_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_flags_q, out_flags_d;
    logic              out_err_q, out_err_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] ra_data, rb_data, wr_data;
    logic [REG_AW-1:0] wr_addr;
    logic              wr_en;
    logic [3:0]        alu_flags;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (in_ra),
        .rb_addr (in_rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (wr_en),
        .wa      (wr_addr),
        .wd      (wr_data)
    );

    always_comb begin
        alu_flags          = '0;
        alu_flags[FLAG_C]  = alu_c;
        alu_flags[FLAG_Z]  = alu_z;
        alu_flags[FLAG_N]  = alu_n;
        alu_flags[FLAG_OV] = alu_ov;
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        op_sel_d    = op_sel_q;
        flags_d     = flags_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        wr_en       = 1'b0;
        wr_addr     = in_rd;
        wr_data     = in_imm;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_alu_op(in_op)) begin
                        // Operands come from the pre-write register values; write-back lands at capture.
                        alu_a_d  = ra_data;
                        alu_b_d  = rb_data;
                        op_sel_d = in_op;
                        rd_d     = in_rd;
                        cnt_d    = CNT_W'(ALU_WAIT - 1);
                        state_d  = ST_EXEC;
                    end else if (in_op == OP_LDI) begin
                        wr_en       = 1'b1;
                        out_data_d  = in_imm;
                        out_flags_d = flags_q;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        out_data_d  = '0;
                        out_flags_d = flags_q;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    wr_en       = 1'b1;
                    wr_addr     = rd_q;
                    wr_data     = alu_result;
                    flags_d     = alu_flags;
                    out_data_d  = alu_result;
                    out_flags_d = alu_flags;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            op_sel_q    <= '0;
            flags_q     <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            op_sel_q    <= op_sel_d;
            flags_q     <= flags_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op_sel = op_sel_q;
    assign out_data   = out_data_q;
    assign out_flags  = out_flags_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;

endmodule
